// File: rtl/mem_stage.sv
// Memory-access pipeline stage: latches the execute bundle, captures SRAM load data and builds the write-back bundle.
// Optional load-misalignment detection is enabled by defining MS_LOAD_ALE_EN.
module mem_stage #(
    parameter int EX_ZIP_W = 81,
    parameter int LD_OP_W  = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                es_to_ms_valid,
    output logic                ms_allowin,
    input  logic [31:0]         es_pc,
    input  logic                es_rf_we,
    input  logic [4:0]          es_rf_waddr,
    input  logic [31:0]         es_alu_result,
    input  logic                es_res_from_mem,
    input  logic [LD_OP_W-1:0]  es_ld_inst,
    input  logic                es_csr_re,
    input  logic [EX_ZIP_W-1:0] es_ex_zip,
    input  logic [31:0]         data_sram_rdata,
    input  logic                ws_allowin,
    input  logic                wb_ex,
    output logic                ms_to_ws_valid,
    output logic [31:0]         ms_pc,
    output logic                ms_rf_we,
    output logic [4:0]          ms_rf_waddr,
    output logic [31:0]         ms_rf_wdata,
    output logic                ms_res_from_mem,
    output logic                ms_csr_re,
    output logic [EX_ZIP_W-1:0] ms_ex_zip,
    output logic                ms_ex,
    output logic                ms_ale,
    output logic [31:0]         ms_badv
);

    logic                ms_valid_q, ms_valid_d;
    logic [31:0]         pc_q;
    logic                rf_we_q;
    logic [4:0]          rf_waddr_q;
    logic [31:0]         alu_result_q;
    logic                res_from_mem_q;
    logic [LD_OP_W-1:0]  ld_inst_q;
    logic                csr_re_q;
    logic [EX_ZIP_W-1:0] ex_zip_q;
    logic                first_q, first_d;
    logic [31:0]         buf_q, buf_d;
    logic                buf_valid_q, buf_valid_d;

    logic        accept;
    logic [1:0]  addr;
    logic [31:0] load_src;
    logic [31:0] shifted;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic        ale;

    assign ms_allowin     = !ms_valid_q || ws_allowin;
    assign ms_to_ws_valid = ms_valid_q;
    assign accept         = es_to_ms_valid && ms_allowin;
    assign addr           = alu_result_q[1:0];

    always_comb begin
        ms_valid_d = ms_valid_q;
        if (wb_ex)
            ms_valid_d = 1'b0;
        else if (ms_allowin)
            ms_valid_d = es_to_ms_valid;
    end

    // SRAM data is only valid in the first cycle after the request, so a
    // stall starting in that cycle must snapshot it for the rest of the stall.
    always_comb begin
        first_d     = accept;
        buf_d       = buf_q;
        buf_valid_d = buf_valid_q;
        if (wb_ex || accept) begin
            buf_valid_d = 1'b0;
        end else if (first_q && ms_valid_q && !ws_allowin) begin
            buf_d       = data_sram_rdata;
            buf_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ms_valid_q     <= 1'b0;
            pc_q           <= '0;
            rf_we_q        <= 1'b0;
            rf_waddr_q     <= '0;
            alu_result_q   <= '0;
            res_from_mem_q <= 1'b0;
            ld_inst_q      <= '0;
            csr_re_q       <= 1'b0;
            ex_zip_q       <= '0;
            first_q        <= 1'b0;
            buf_q          <= '0;
            buf_valid_q    <= 1'b0;
        end else begin
            ms_valid_q  <= ms_valid_d;
            first_q     <= first_d;
            buf_q       <= buf_d;
            buf_valid_q <= buf_valid_d;
            if (accept) begin
                pc_q           <= es_pc;
                rf_we_q        <= es_rf_we;
                rf_waddr_q     <= es_rf_waddr;
                alu_result_q   <= es_alu_result;
                res_from_mem_q <= es_res_from_mem;
                ld_inst_q      <= es_ld_inst;
                csr_re_q       <= es_csr_re;
                ex_zip_q       <= es_ex_zip;
            end
        end
    end

    always_comb begin
        load_src = buf_valid_q ? buf_q : data_sram_rdata;
        shifted  = load_src >> {addr, 3'b000};
        byte_v   = shifted[7:0];
        half_v   = addr[1] ? load_src[31:16] : load_src[15:0];
        if (ld_inst_q[0])
            ms_rf_wdata = {{24{byte_v[7]}}, byte_v};
        else if (ld_inst_q[1])
            ms_rf_wdata = {24'h0, byte_v};
        else if (ld_inst_q[2])
            ms_rf_wdata = {{16{half_v[15]}}, half_v};
        else if (ld_inst_q[3])
            ms_rf_wdata = {16'h0, half_v};
        else if (ld_inst_q[4])
            ms_rf_wdata = load_src;
        else
            ms_rf_wdata = alu_result_q;
    end

`ifdef MS_LOAD_ALE_EN
    assign ale = ms_valid_q && res_from_mem_q &&
                 (((ld_inst_q[2] || ld_inst_q[3]) && addr[0]) ||
                  (ld_inst_q[4] && (addr != 2'b00)));
`else
    assign ale = 1'b0;
`endif

    assign ms_ale          = ale;
    assign ms_ex           = ms_valid_q && (ex_zip_q[1] || ex_zip_q[0] || ale);
    assign ms_badv         = alu_result_q;
    assign ms_pc           = pc_q;
    assign ms_rf_we        = ms_valid_q && rf_we_q && !ms_ex;
    assign ms_rf_waddr     = rf_waddr_q;
    assign ms_res_from_mem = ms_valid_q && res_from_mem_q;
    assign ms_csr_re       = ms_valid_q && csr_re_q;
    assign ms_ex_zip       = ex_zip_q;

endmodule
